// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks a one-hot digit enable and drives the matching BCD code.
// New digit values are staged and committed only at frame wraps (or while dark) so the display never tears.
module seven_seg_scan_ctrl #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         REFRESH_DIV = 1000,
  parameter logic [3:0] BLANK_CODE  = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic                    run;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [4*NUM_DIGITS-1:0] display;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    commit;
  logic                    new_slot;
  logic [IW-1:0]           idx_next;
  logic [4*NUM_DIGITS-1:0] display_next;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [3:0]              next_code;

  // run marks that a slot is already lit; the first enabled edge only lights digit 0
  always_comb begin
    slot_end     = run && (prescaler == PS_LAST);
    frame_wrap   = slot_end && (idx == IDX_LAST);
    commit       = pending && (!enable || frame_wrap);
    new_slot     = enable && (!run || slot_end);
    display_next = commit ? staging : display;
    idx_next     = idx;
    if (!enable || !run || frame_wrap) begin
      idx_next = '0;
    end else if (slot_end) begin
      idx_next = idx + 1'b1;
    end
  end

  // a digit is blanked when it and every more-significant digit are zero
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above    = zero_above && (display_next[4*k +: 4] == 4'h0);
      blank_mask[k] = blank_lz && zero_above && (k > 0);
    end
    next_code = blank_mask[idx_next] ? BLANK_CODE : display_next[{idx_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      run        <= 1'b0;
      staging    <= {NUM_DIGITS{BLANK_CODE}};
      display    <= {NUM_DIGITS{BLANK_CODE}};
      pending    <= 1'b0;
      frame_done <= 1'b0;
      bcd_out    <= BLANK_CODE;
      digit_en   <= '0;
    end else begin
      run        <= enable;
      frame_done <= enable && frame_wrap;
      if (commit) begin
        display <= staging;
      end
      // a load in the commit cycle replaces staging after the old value moved to display
      if (load) begin
        staging <= bcd_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      if (!enable) begin
        prescaler <= '0;
        idx       <= '0;
        digit_en  <= '0;
        bcd_out   <= BLANK_CODE;
      end else if (new_slot) begin
        prescaler <= '0;
        idx       <= idx_next;
        digit_en  <= NUM_DIGITS'(1) << idx_next;
        bcd_out   <= next_code;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller that shares one `seven_seg_bcd` decoder among NUM_DIGITS common-cathode digits. It holds a frame of BCD digits, walks a one-hot digit enable at a fixed refresh rate and drives the matching 4-bit code into the decoder. New values are committed only at frame boundaries, so the display never tears. Optional leading-zero suppression uses the decoder's all-off default for codes above 9.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 1000, clock cycles each digit stays lit (≥2).
- BLANK_CODE, 4'hF, code sent to the decoder for a dark digit; the decoder maps it to 7'b0000000.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = scan running, 0 = display dark.
- load  input  1  single-cycle strobe; captures bcd_in into staging.
- bcd_in  input  4*NUM_DIGITS  digit values; [3:0] = digit 0 (rightmost, least significant).
- blank_lz  input  1  1 = suppress leading zeros.
- bcd_out  output  4  code to the decoder `in` port.
- digit_en  output  NUM_DIGITS  one-hot active-high digit select.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.
- pending  output  1  staging holds data not yet displayed.

## Operation
- State:
  - prescaler, width clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1.
  - idx, width clog2(NUM_DIGITS).
  - staging register and display register, each 4*NUM_DIGITS bits.
  - pending flag.
- Reset (async, rst_n=0):
  - prescaler=0, idx=0, pending=0, frame_done=0.
  - staging and display are all BLANK_CODE.
  - bcd_out=BLANK_CODE, digit_en=0.
- Load:
  - When load=1, staging<=bcd_in and pending<=1.
  - Back-to-back loads: the last one wins and pending stays 1.
  - bcd_in is not validated; codes 10..15 pass through and the decoder shows them dark.
- Commit:
  - At a frame wrap with pending=1: display<=staging and pending<=0.
  - If load and the commit happen in the same cycle, the old staging is committed, the new value is captured into staging, and pending stays 1.
  - While enable=0, commit happens on every cycle that pending=1, because there is no visible tearing.
- Scan (enable=1):
  - prescaler increments each cycle.
  - At REFRESH_DIV-1, prescaler wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0; this wrap is the frame wrap and fires frame_done.
- Blanking:
  - With blank_lz=1, digit k is blanked when display digits NUM_DIGITS-1..k are all 4'h0 and k>0.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - Blanked digits drive bcd_out=BLANK_CODE; digit_en still walks through them.
- Disable:
  - enable=0 synchronously clears prescaler and idx and drives digit_en=0 and bcd_out=BLANK_CODE.
  - Re-enable starts at digit 0 with a full REFRESH_DIV slot.

## Timing
- bcd_out, digit_en and frame_done are registered and change on the same edge as idx.
- First active cycle after reset release with enable=1: digit_en=1 (digit 0) and bcd_out=display[3:0].
- Each digit is lit for exactly REFRESH_DIV cycles; a full frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_done is high for the first cycle of the new frame, i.e. the cycle in which digit_en returns to digit 0.
- A committed value is visible from that same cycle.
- Load-to-display latency:
  - Worst case NUM_DIGITS*REFRESH_DIV cycles plus 1.
  - Best case 1 cycle, when load lands on the cycle just before the frame wrap.
- Toggling blank_lz takes effect on the next digit slot, not mid-slot.
- Reset asserted mid-frame drops outputs immediately (async), discards staging and pending, and blanks the display.
- digit_en is never multi-hot, including across wraps and enable toggles.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset release with enable=1 and no load: digit_en cycles 0001→0010→0100→1000 every 4 clocks, bcd_out=4'hF throughout, frame_done every 16 clocks.
- load with bcd_in=16'h1234 mid-frame: pending=1 until the wrap; from the next frame bcd_out reads 4,3,2,1 with digit_en 0001..1000; pending=0.
- blank_lz=1, load 16'h0070: digits 3 and 2 get 4'hF, digit 1 gets 7, digit 0 gets 0; load 16'h0000 gives only digit 0 = 0, the rest 4'hF.
- Loads of 16'h1111 and then 16'h2222 before the wrap: only 2222 is displayed. A load coinciding with the wrap commits the old staging and keeps pending=1 for the next frame.
- enable dropped mid-slot: next cycle digit_en=0 and bcd_out=4'hF; a load while disabled commits immediately; re-enable restarts at digit 0 with a 4-cycle slot.
- rst_n pulsed low mid-frame after displaying 16'h9876: outputs go dark asynchronously, display resets to blank, pending=0, and the scan restarts at digit 0.
